// File: rtl/mem_arbiter_2p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_2p_pkg
// Brief    : Shared widths, FSM encodings and helpers for the 2-port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arbiter_2p_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int ADDRESS_WIDTH = 32;

   typedef logic port_id_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_CAPT  = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_ACK      = 3'd4
   } state_t;

   // States in which the memory address bus carries the latched address.
   function automatic logic addr_phase(input state_t s);
      return (s == ST_RD_ISSUE) || (s == ST_RD_CAPT) || (s == ST_WR_ISSUE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_2p_rr_arb_2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_2
// Brief    : Two-requester arbiter, round-robin or fixed priority to port 0.
// Revision : 1.0
// ============================================================================
module rr_arb_2
   import mem_arbiter_2p_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_rr_en,
   input  port_id_t   i_last_grant,
   output port_id_t   o_grant,
   output logic       o_valid
);

   always_comb begin
      o_valid = |i_req;
      o_grant = 1'b0;
      case (i_req)
         2'b01:   o_grant = 1'b0;
         2'b10:   o_grant = 1'b1;
         2'b11:   o_grant = i_rr_en ? ~i_last_grant : 1'b0;
         default: o_grant = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_2p
// Brief    : Two-port arbiter onto a single external memory, registered outputs.
// Revision : 1.0
// ============================================================================
module mem_arbiter_2p
   import mem_arbiter_2p_pkg::*;
#(
   parameter bit RR_EN = 1'b1
)
(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     P0_REQ,
   input  logic                     P0_WE,
   input  logic [ADDRESS_WIDTH-1:0] P0_ADDR,
   input  logic [DATA_WIDTH-1:0]    P0_WDATA,
   output logic [DATA_WIDTH-1:0]    P0_RDATA,
   output logic                     P0_ACK,
   input  logic                     P1_REQ,
   input  logic                     P1_WE,
   input  logic [ADDRESS_WIDTH-1:0] P1_ADDR,
   input  logic [DATA_WIDTH-1:0]    P1_WDATA,
   output logic [DATA_WIDTH-1:0]    P1_RDATA,
   output logic                     P1_ACK,
   output logic                     MEM_READ,
   output logic                     MEM_WRITE,
   output logic [ADDRESS_WIDTH-1:0] MEM_ADDR,
   inout  wire  [DATA_WIDTH-1:0]    MEM_DATA,
   output logic                     BUSY
);

   state_t                    r_state, w_next_state;
   port_id_t                  r_grant, w_grant_next;
   port_id_t                  r_last_grant, w_last_next;
   logic                      r_we, w_we_next;
   logic [ADDRESS_WIDTH-1:0]  r_addr, w_addr_next;
   logic [DATA_WIDTH-1:0]     r_wdata, w_wdata_next;

   logic                      r_mem_read, r_mem_write, r_drive_en;
   logic [ADDRESS_WIDTH-1:0]  r_mem_addr;
   logic                      r_p0_ack, r_p1_ack, r_busy;
   logic [DATA_WIDTH-1:0]     r_p0_rdata, r_p1_rdata;

   port_id_t                  w_arb_grant;
   logic                      w_arb_valid;

   rr_arb_2 u_arb (
      .i_req        ({P1_REQ, P0_REQ}),
      .i_rr_en      (RR_EN),
      .i_last_grant (r_last_grant),
      .o_grant      (w_arb_grant),
      .o_valid      (w_arb_valid)
   );

   always_comb begin
      w_next_state = r_state;
      w_grant_next = r_grant;
      w_last_next  = r_last_grant;
      w_we_next    = r_we;
      w_addr_next  = r_addr;
      w_wdata_next = r_wdata;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_valid) begin
               w_grant_next = w_arb_grant;
               w_last_next  = w_arb_grant;
               w_we_next    = w_arb_grant ? P1_WE    : P0_WE;
               w_addr_next  = w_arb_grant ? P1_ADDR  : P0_ADDR;
               w_wdata_next = w_arb_grant ? P1_WDATA : P0_WDATA;
               w_next_state = w_we_next ? ST_WR_ISSUE : ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: w_next_state = ST_RD_CAPT;
         ST_RD_CAPT:  w_next_state = ST_ACK;
         ST_WR_ISSUE: w_next_state = ST_ACK;
         ST_ACK:      w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_drive_en   <= 1'b0;
         r_mem_addr   <= '0;
         r_p0_ack     <= 1'b0;
         r_p1_ack     <= 1'b0;
         r_busy       <= 1'b0;
         r_p0_rdata   <= '0;
         r_p1_rdata   <= '0;
      end else begin
         r_state      <= w_next_state;
         r_grant      <= w_grant_next;
         r_last_grant <= w_last_next;
         r_we         <= w_we_next;
         r_addr       <= w_addr_next;
         r_wdata      <= w_wdata_next;
         r_mem_read   <= (w_next_state == ST_RD_ISSUE) || (w_next_state == ST_RD_CAPT);
         r_mem_write  <= (w_next_state == ST_WR_ISSUE);
         r_drive_en   <= (w_next_state == ST_WR_ISSUE);
         r_mem_addr   <= addr_phase(w_next_state) ? w_addr_next : '0;
         r_p0_ack     <= (w_next_state == ST_ACK) && !w_grant_next;
         r_p1_ack     <= (w_next_state == ST_ACK) &&  w_grant_next;
         r_busy       <= (w_next_state != ST_IDLE);
         if (r_state == ST_RD_CAPT) begin
            if (r_grant) r_p1_rdata <= MEM_DATA;
            else         r_p0_rdata <= MEM_DATA;
         end
      end
   end

   assign MEM_DATA  = r_drive_en ? r_wdata : {DATA_WIDTH{1'bz}};
   assign MEM_READ  = r_mem_read;
   assign MEM_WRITE = r_mem_write;
   assign MEM_ADDR  = r_mem_addr;
   assign P0_ACK    = r_p0_ack;
   assign P1_ACK    = r_p1_ack;
   assign P0_RDATA  = r_p0_rdata;
   assign P1_RDATA  = r_p1_rdata;
   assign BUSY      = r_busy;

endmodule
`default_nettype wire
